viterbi_state_sequencer: RTL
============================

// Module: viterbi_state_sequencer
// PURPOSE
//  Sequences the 8-state trellis update of the Viterbi decoder. For each accepted
//  received symbol it sweeps trellis states 0..7, driving a 3-bit state index plus
//  an enable into the 3-to-8 one-hot decoder that selects the path-metric/survivor
//  register being written. It counts processed symbols and pulses a traceback start
//  every TB_DEPTH symbols. Sits between the symbol input stage and the ACS/traceback units.
// PARAMETERS
//  TB_DEPTH  16  symbols between traceback start pulses (2..2**CNT_W)
//  CNT_W     5   width of the symbol counter; must satisfy 2**CNT_W >= TB_DEPTH
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous reset, active-high
//  sym_valid   in   1      received symbol available
//  sym_ready   out  1      sequencer can accept a symbol (IDLE)
//  sym_in      in   2      received hard-decision symbol bits
//  abort       in   1      synchronous abort of the current sweep
//  st_idx      out  3      trellis state index; drives the decoder's 3-bit select
//  st_choose   out  1      decoder enable; 1 only while sweeping
//  sym_out     out  2      symbol latched at accept, held for the ACS during the sweep
//  sweep_done  out  1      1-cycle pulse: all 8 states updated for this symbol
//  tb_start    out  1      1-cycle pulse coincident with sweep_done on every TB_DEPTH-th symbol
//  sym_cnt     out  CNT_W  symbols completed since the last traceback, 0..TB_DEPTH-1
// BEHAVIOUR
//  - All outputs registered. Reset values: sym_ready=1, st_idx=0, st_choose=0,
//    sym_out=0, sweep_done=0, tb_start=0, sym_cnt=0, FSM=IDLE.
//  - A sym_valid sampled in a cycle with rst=1 is ignored.
//  - FSM states: IDLE, SWEEP, DONE.
//  - IDLE: sym_ready=1, st_choose=0. Accept = sym_valid & sym_ready & ~abort at edge T0:
//    latch sym_out<=sym_in, st_idx<=0, st_choose<=1, sym_ready<=0, go to SWEEP.
//  - SWEEP: occupies cycles T1..T8 with st_idx=0,1,...,7 and st_choose=1. st_idx
//    increments by 1 each cycle. At st_idx=7, go to DONE (st_choose<=0, st_idx<=0).
//  - DONE (T9): sweep_done=1, st_choose=0.
//    If sym_cnt==TB_DEPTH-1: tb_start=1 and sym_cnt wraps to 0; else sym_cnt+1.
//    sym_cnt holds its new value from T10. Then go to IDLE; sym_ready=1 at T10.
//  - Latency: accept -> first enable 1 cycle; accept -> sweep_done 9 cycles.
//    Throughput: one symbol per 10 cycles. sym_valid held high is accepted at T10.
//  - sym_out is stable from T1 through T9. sym_in changes after the accept edge are ignored.
//  - Decoder invariant: st_choose=1 in exactly 8 consecutive cycles per symbol.
//    Each index 0..7 appears exactly once, in ascending order. st_idx=0 whenever st_choose=0.
//  - abort=1 in any state: next cycle FSM=IDLE, st_choose=0, st_idx=0, sym_ready=1.
//    No sweep_done or tb_start is produced, and sym_cnt is unchanged.
//    abort sampled in IDLE together with sym_valid: abort wins, no accept.
//  - abort sampled in DONE: the sweep_done/tb_start pulses of that cycle have
//    already been issued and the sym_cnt update has taken effect. FSM returns to IDLE
//    normally.
//  - rst mid-sweep: same as reset values on the next cycle.
//    sym_cnt clears to 0 (unlike abort).
//  - rst has priority over abort, and abort has priority over a handshake.
// TESTING
//  1. Reset, then sym_valid=1, sym_in=2'b10 for one cycle -> st_choose=1 T1..T8;
//     st_idx 0..7; sym_out=2'b10; sweep_done=1 at T9 only; sym_ready=1 at T10; sym_cnt=1.
//  2. sym_valid held high for 3 symbols -> accepts spaced exactly 10 cycles apart;
//     sym_ready=0 T1..T9 each time; sym_cnt reads 3 at the end.
//  3. TB_DEPTH=16, 16 back-to-back symbols -> tb_start=1 only with the 16th sweep_done;
//     sym_cnt goes 15 -> 0; 17th symbol gives sym_cnt=1, tb_start=0.
//  4. abort=1 at T4 (st_idx=3) -> T5: st_choose=0, st_idx=0, sym_ready=1;
//     no sweep_done; sym_cnt unchanged; the next symbol sweeps a full 0..7.
//  5. rst=1 at T6 after 5 completed symbols -> next cycle: all outputs at reset values,
//     sym_cnt=0; sym_valid asserted during the rst cycle is not accepted.
//  6. Check the decoder model: the one-hot of st_idx gated by st_choose has popcount 1
//     on 8 cycles per symbol and 0 otherwise; abort+sym_valid in IDLE -> no accept.

Source files
------------

// File: rtl/viterbi_state_sequencer.sv
// Trellis sweep sequencer: for each accepted symbol, walks state indices 0..7
// into the path-metric decoder, counts symbols and pulses traceback every TB_DEPTH.
module viterbi_state_sequencer #(
  parameter int TB_DEPTH = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [1:0]       sym_in,
  input  logic             abort,
  output logic [2:0]       st_idx,
  output logic             st_choose,
  output logic [1:0]       sym_out,
  output logic             sweep_done,
  output logic             tb_start,
  output logic [CNT_W-1:0] sym_cnt
);

  // state  | meaning
  // IDLE   | waiting for a symbol, sym_ready=1
  // SWEEP  | driving st_idx 0..7 with st_choose=1
  // DONE   | sweep_done (and maybe tb_start) visible, symbol count updates
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

  state_t           state_q, state_d;
  logic             sym_ready_q, sym_ready_d;
  logic [2:0]       st_idx_q, st_idx_d;
  logic             st_choose_q, st_choose_d;
  logic [1:0]       sym_out_q, sym_out_d;
  logic             sweep_done_q, sweep_done_d;
  logic             tb_start_q, tb_start_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;

  always_comb begin
    state_d      = state_q;
    sym_ready_d  = sym_ready_q;
    st_idx_d     = st_idx_q;
    st_choose_d  = st_choose_q;
    sym_out_d    = sym_out_q;
    sweep_done_d = 1'b0;
    tb_start_d   = 1'b0;
    sym_cnt_d    = sym_cnt_q;

    case (state_q)
      IDLE: begin
        sym_ready_d = 1'b1;
        st_choose_d = 1'b0;
        st_idx_d    = 3'd0;
        if (sym_valid && sym_ready_q && !abort) begin
          sym_out_d   = sym_in;
          st_choose_d = 1'b1;
          sym_ready_d = 1'b0;
          state_d     = SWEEP;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d     = IDLE;
          st_choose_d = 1'b0;
          st_idx_d    = 3'd0;
          sym_ready_d = 1'b1;
        end else if (st_idx_q == 3'd7) begin
          state_d      = DONE;
          st_choose_d  = 1'b0;
          st_idx_d     = 3'd0;
          sweep_done_d = 1'b1;
          tb_start_d   = (sym_cnt_q == CNT_LAST);
        end else begin
          st_idx_d = st_idx_q + 3'd1;
        end
      end
      DONE: begin
        // pulses are already out, so abort here changes nothing; the count always commits
        sym_cnt_d   = (sym_cnt_q == CNT_LAST) ? '0 : sym_cnt_q + 1'b1;
        sym_ready_d = 1'b1;
        st_choose_d = 1'b0;
        st_idx_d    = 3'd0;
        state_d     = IDLE;
      end
      default: begin
        state_d     = IDLE;
        sym_ready_d = 1'b1;
        st_choose_d = 1'b0;
        st_idx_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sym_ready_q  <= 1'b1;
      st_idx_q     <= 3'd0;
      st_choose_q  <= 1'b0;
      sym_out_q    <= 2'b00;
      sweep_done_q <= 1'b0;
      tb_start_q   <= 1'b0;
      sym_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sym_ready_q  <= sym_ready_d;
      st_idx_q     <= st_idx_d;
      st_choose_q  <= st_choose_d;
      sym_out_q    <= sym_out_d;
      sweep_done_q <= sweep_done_d;
      tb_start_q   <= tb_start_d;
      sym_cnt_q    <= sym_cnt_d;
    end
  end

  assign sym_ready  = sym_ready_q;
  assign st_idx     = st_idx_q;
  assign st_choose  = st_choose_q;
  assign sym_out    = sym_out_q;
  assign sweep_done = sweep_done_q;
  assign tb_start   = tb_start_q;
  assign sym_cnt    = sym_cnt_q;

endmodule
